irq_pending: RTL and testbench
==============================

# irq_pending

Peripheral-side interrupt request front end for the CPU's interrupt controller. It takes eight raw, asynchronous peripheral event lines, synchronizes them, and captures each one as either a latched edge event or a live level. It drives the controller's 8-bit `interrupts` request vector. Pending edge requests clear when the controller acknowledges the serviced vector or when software clears them.

## Interface
Parameters:
- `N_IRQ`, 8: number of request lines; the controller vector map is fixed for 8.
- `VEC_BASE`, 16'hFFF8: vector address of line 0. Line k uses `VEC_BASE + k`.

Ports:
- `CLK`  in  1  single clock; all state updates on posedge.
- `RST`  in  1  asynchronous, active-high reset.
- `irq_in`  in  8  raw peripheral event lines, asynchronous to `CLK`.
- `edge_en`  in  8  per line: 1 = rising-edge latched, 0 = level pass-through.
- `ack`  in  1  one-cycle pulse from the controller when it commits a vector.
- `ack_vector`  in  16  vector address being serviced; sampled only when `ack`=1.
- `clr_we`  in  1  software clear strobe.
- `clr_mask`  in  8  lines to clear when `clr_we`=1.
- `interrupts`  out  8  request vector to the controller (bit 0 = highest priority).
- `irq_any`  out  1  OR of `interrupts`.
- `overflow`  out  8  sticky flag: an edge arrived while that line was already pending.

## Operation
- Each line has a synchronizer `s1 -> s2` and a history flop `s3`. All reset to 0.
- `rise[k] = s2[k] & ~s3[k]`.
- Edge mode (`edge_en[k]`=1):
  - `pend[k]` sets on `rise[k]`.
  - `pend[k]` clears on a matching ack or on a software clear.
  - `interrupts[k] = pend[k]`.
- Level mode (`edge_en[k]`=0):
  - `interrupts[k] = s2[k]`.
  - `pend[k]` is forced to 0 on the next posedge.
  - `ack` and `clr` have no effect on the request; the bit drops only when the source drops.
  - `overflow[k]` never sets.
- Ack match: `ack`=1 and `ack_vector[15:3] == VEC_BASE[15:3]`. Index `k = ack_vector[2:0]`; only `pend[k]` clears. A non-matching `ack_vector` is ignored with no state change.
- Software clear: `clr_we`=1 clears `pend[k]` and `overflow[k]` for every k with `clr_mask[k]`=1.
- Overflow: `rise[k]` while `pend[k]`=1 (and that line is not being cleared this cycle) sets `overflow[k]`. The flag is sticky until a software clear.
- Simultaneous events, per line, same cycle:
  - `rise` + ack clear: set wins; `pend` stays 1; no overflow.
  - `rise` + software clear: set wins; `pend`=1; `overflow` cleared.
  - ack + software clear: cleared.
- Mode switch level→edge with the source high: no edge is generated. A new 0→1 on `s2` is required.
- Mode switch edge→level: `pend[k]` and any pending event on that line are discarded.

## Timing
- Reset (async, immediate): `s1`/`s2`/`s3`/`pend`/`overflow` = 0, so `interrupts`=0, `irq_any`=0, `overflow`=0.
- An `irq_in` held high through reset release is seen as a rising edge.
- Edge latency: an `irq_in` rise captured at posedge P0 gives `pend`/`interrupts` high after posedge P0+2, which is the third posedge counting P0.
- Level latency: `interrupts[k]` follows `irq_in` with 2 posedges of delay, both rising and falling.
- Minimum detectable pulse: one full `CLK` period high, then one period low before the next edge counts.
- Ack and clear take effect at the posedge where they are sampled. `interrupts` is low from that posedge on.
- The controller updates on the negedge. `interrupts` changes only after a posedge, so it is stable for a half period before the controller samples it.
- `irq_any` is combinational from the registered `pend`/`s2` state; it has no extra delay.
- Reset mid-operation discards all pending events and overflow flags; there is no recovery.

## Test plan
- Reset and idle:
  - assert `RST` with `irq_in`=8'h00 -> `interrupts`=0, `overflow`=0, `irq_any`=0.
  - release `RST` -> these stay 0 for 10 cycles.
- Edge latch and ack:
  - `edge_en`=8'hFF; pulse `irq_in[2]` high for 1 cycle -> `interrupts`=8'h04 three posedges later, held.
  - `ack`=1, `ack_vector`=16'hFFFA -> `interrupts`=8'h00 next cycle.
  - `ack_vector`=16'h1234 -> no change.
- Level mode:
  - `edge_en`=8'h00; `irq_in`=8'h81 for 5 cycles -> `interrupts`=8'h81 from cycle 2 through 6.
  - `ack` on 16'hFFF8 -> no effect.
  - drop `irq_in` -> `interrupts`=0 two cycles later.
- Overflow:
  - edge mode, two pulses on line 5 without ack -> `overflow`=8'h20, `interrupts`=8'h20.
  - `clr_we`=1, `clr_mask`=8'h20 -> both 0.
- Simultaneous:
  - `rise` on line 0 in the same cycle as an `ack` on 16'hFFF8 -> `interrupts[0]` stays 1, `overflow[0]`=0.
- Async reset mid-operation:
  - `interrupts`=8'h0F, `overflow`=8'h01.
  - pulse `RST` between clock edges -> all outputs 0 immediately.

Source files
------------

// File: rtl/irq_pending.sv
`timescale 1ns/1ps
// irq_pending
// Peripheral-side interrupt request front end. Eight asynchronous event
// lines are synchronized. Each line is then either latched on a rising edge
// or passed through as a level. The result drives the controller's request
// vector.
//
// Ports:
//   CLK         clock, all state updates on posedge
//   RST         asynchronous active-high reset
//   irq_in      raw peripheral event lines (asynchronous)
//   edge_en     per line: 1 = rising-edge latched, 0 = level pass-through
//   ack         one-cycle acknowledge pulse from the controller
//   ack_vector  vector address being serviced (valid with ack)
//   clr_we      software clear strobe
//   clr_mask    lines to clear when clr_we = 1
//   interrupts  request vector, bit 0 = highest priority
//   irq_any     OR of interrupts
//   overflow    sticky: an edge arrived while the line was already pending
module irq_pending #(
  parameter int unsigned N_IRQ    = 8,
  parameter logic [15:0] VEC_BASE = 16'hFFF8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [N_IRQ-1:0] irq_in,
  input  logic [N_IRQ-1:0] edge_en,
  input  logic             ack,
  input  logic [15:0]      ack_vector,
  input  logic             clr_we,
  input  logic [N_IRQ-1:0] clr_mask,
  output logic [N_IRQ-1:0] interrupts,
  output logic             irq_any,
  output logic [N_IRQ-1:0] overflow
);

  logic [N_IRQ-1:0] r_s1, r_s2, r_s3;
  logic [N_IRQ-1:0] r_pend, r_ovf;

  logic             w_ack_hit;
  logic [N_IRQ-1:0] w_rise;
  logic [N_IRQ-1:0] w_ack_clr;
  logic [N_IRQ-1:0] w_sw_clr;
  logic [N_IRQ-1:0] w_pend_nxt;
  logic [N_IRQ-1:0] w_ovf_nxt;

  // The history flop tracks s2 in both modes. A level->edge switch with the
  // source already high therefore sees no 0->1 transition and raises nothing.
  assign w_rise    = r_s2 & ~r_s3;
  assign w_ack_hit = ack && (ack_vector[15:3] == VEC_BASE[15:3]);
  assign w_sw_clr  = clr_we ? clr_mask : '0;

  always_comb begin
    w_ack_clr = '0;
    if (w_ack_hit) begin
      w_ack_clr[ack_vector[2:0]] = 1'b1;
    end
  end

  // A rise wins over any clear in the same cycle. Level-mode lines hold pend
  // at 0, which also discards anything latched before an edge->level switch.
  assign w_pend_nxt = edge_en & (w_rise | (r_pend & ~w_ack_clr & ~w_sw_clr));

  // Overflow only sets when the line stays pending through this cycle.
  // A rise coinciding with an ack or clear re-arms the line instead.
  assign w_ovf_nxt  = (r_ovf & ~w_sw_clr)
                    | (edge_en & w_rise & r_pend & ~w_ack_clr & ~w_sw_clr);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_s1   <= '0;
      r_s2   <= '0;
      r_s3   <= '0;
      r_pend <= '0;
      r_ovf  <= '0;
    end else begin
      r_s1   <= irq_in;
      r_s2   <= r_s1;
      r_s3   <= r_s2;
      r_pend <= w_pend_nxt;
      r_ovf  <= w_ovf_nxt;
    end
  end

  assign interrupts = (edge_en & r_pend) | (~edge_en & r_s2);
  assign irq_any    = |interrupts;
  assign overflow   = r_ovf;

endmodule

// File: tb/tb_irq_pending.sv
`timescale 1ns/1ps
module tb_irq_pending;

  logic        CLK = 1'b0;
  logic        RST;
  logic [7:0]  irq_in;
  logic [7:0]  edge_en;
  logic        ack;
  logic [15:0] ack_vector;
  logic        clr_we;
  logic [7:0]  clr_mask;
  logic [7:0]  interrupts;
  logic        irq_any;
  logic [7:0]  overflow;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string      tag;
    logic [7:0] intr;
    logic [7:0] ovf;
  } exp_t;

  exp_t sb[$];

  irq_pending #(.N_IRQ(8), .VEC_BASE(16'hFFF8)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .irq_in     (irq_in),
    .edge_en    (edge_en),
    .ack        (ack),
    .ack_vector (ack_vector),
    .clr_we     (clr_we),
    .clr_mask   (clr_mask),
    .interrupts (interrupts),
    .irq_any    (irq_any),
    .overflow   (overflow)
  );

  always #5 CLK = ~CLK;

  task automatic push_exp(input string tag, input logic [7:0] i, input logic [7:0] o);
    exp_t e;
    e.tag  = tag;
    e.intr = i;
    e.ovf  = o;
    sb.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL scoreboard_empty obs=0 exp=nonzero");
      return;
    end
    e = sb.pop_front();
    checks++;
    assert (interrupts === e.intr) else begin
      failures++;
      $error("FAIL %s.interrupts obs=%h exp=%h", e.tag, interrupts, e.intr);
    end
    checks++;
    assert (overflow === e.ovf) else begin
      failures++;
      $error("FAIL %s.overflow obs=%h exp=%h", e.tag, overflow, e.ovf);
    end
    checks++;
    assert (irq_any === (|e.intr)) else begin
      failures++;
      $error("FAIL %s.irq_any obs=%b exp=%b", e.tag, irq_any, |e.intr);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge CLK);
  endtask

  initial begin
    RST = 1'b0; irq_in = '0; edge_en = 8'hFF; ack = 1'b0;
    ack_vector = '0; clr_we = 1'b0; clr_mask = '0;

    // Reset asserted between edges
    #2 RST = 1'b1;
    #1 push_exp("reset", 8'h00, 8'h00);
    pop_check();
    step(1);
    RST = 1'b0;
    for (int c = 0; c < 10; c++) begin
      push_exp("idle", 8'h00, 8'h00);
      step(1);
      pop_check();
    end

    // Edge latch: one-cycle pulse on line 2, visible after the third posedge
    irq_in = 8'h04;
    push_exp("edge_p0", 8'h00, 8'h00);
    push_exp("edge_p1", 8'h00, 8'h00);
    push_exp("edge_p2", 8'h04, 8'h00);
    step(1); pop_check(); irq_in = 8'h00;
    step(1); pop_check();
    step(1); pop_check();
    push_exp("edge_hold", 8'h04, 8'h00);
    step(2); pop_check();

    // Non-matching ack is ignored, matching ack clears line 2
    ack = 1'b1; ack_vector = 16'h1234;
    push_exp("ack_nomatch", 8'h04, 8'h00);
    step(1); pop_check();
    ack_vector = 16'hFFFA;
    push_exp("ack_match", 8'h00, 8'h00);
    step(1); pop_check();
    ack = 1'b0;

    // Level mode: 5 cycles high on lines 0 and 7
    edge_en = 8'h00;
    irq_in  = 8'h81;
    for (int c = 1; c <= 7; c++) begin
      push_exp("level", (c >= 2 && c <= 6) ? 8'h81 : 8'h00, 8'h00);
      step(1);
      pop_check();
      ack = (c == 3);
      ack_vector = 16'hFFF8;
      if (c == 5) irq_in = 8'h00;
    end
    ack = 1'b0;

    // Overflow: two pulses on line 5 without ack
    edge_en = 8'hFF;
    step(1);
    irq_in = 8'h20; step(1);
    irq_in = 8'h00; step(1);
    irq_in = 8'h20; step(1);
    irq_in = 8'h00;
    push_exp("overflow", 8'h20, 8'h20);
    step(2); pop_check();
    clr_we = 1'b1; clr_mask = 8'h20;
    push_exp("sw_clear", 8'h00, 8'h00);
    step(1); pop_check();
    clr_we = 1'b0; clr_mask = 8'h00;

    // Rise on line 0 coincident with a matching ack: set wins, no overflow
    irq_in = 8'h01; step(1);
    irq_in = 8'h00;
    push_exp("simul_pre", 8'h01, 8'h00);
    step(2); pop_check();
    irq_in = 8'h01; step(1);
    irq_in = 8'h00; step(1);
    ack = 1'b1; ack_vector = 16'hFFF8;
    push_exp("simul_rise_ack", 8'h01, 8'h00);
    step(1); pop_check();
    push_exp("ack_line0", 8'h00, 8'h00);
    step(1); pop_check();
    ack = 1'b0;

    // Build interrupts=0F, overflow=01 then async reset between edges
    irq_in = 8'h0F; step(1);
    irq_in = 8'h00; step(1);
    irq_in = 8'h01; step(1);
    irq_in = 8'h00;
    push_exp("pre_reset", 8'h0F, 8'h01);
    step(2); pop_check();
    #2 RST = 1'b1;
    push_exp("async_reset", 8'h00, 8'h00);
    #1 pop_check();
    #1 RST = 1'b0;
    push_exp("post_reset", 8'h00, 8'h00);
    step(3); pop_check();

    checks++;
    assert (sb.size() == 0) else begin
      failures++;
      $error("FAIL scoreboard_leftover obs=%0d exp=0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
